// File: rtl/aes_edn_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_edn_arbiter_if
// Brief    : Requester / EDN handshake bundle for the AES EDN arbiter.
// Revision : 1.0
// ============================================================================
interface aes_edn_arbiter_if #(
    parameter int NumReq       = 2,
    parameter int EntropyWidth = 32
);
    localparam int IdxW = $clog2(NumReq);

    logic [NumReq-1:0]       req_i;
    logic [NumReq-1:0]       ack_o;
    logic [EntropyWidth-1:0] data_o;
    logic                    edn_req_o;
    logic                    edn_ack_i;
    logic [EntropyWidth-1:0] edn_data_i;
    logic [IdxW-1:0]         gnt_idx_o;
    logic                    idle_o;
    logic                    err_o;

    // Arbiter side
    modport slave (
        input  req_i, edn_ack_i, edn_data_i,
        output ack_o, data_o, edn_req_o, gnt_idx_o, idle_o, err_o
    );

    // Requester / EDN side
    modport master (
        output req_i, edn_ack_i, edn_data_i,
        input  ack_o, data_o, edn_req_o, gnt_idx_o, idle_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/aes_edn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_edn_arbiter
// Brief    : Shares one EDN entropy port between NumReq requesters, fixed
//            priority with starvation promotion; AES_EDN_ARB_RR_EN selects
//            round-robin among non-starved requesters.
// Revision : 1.0
// ============================================================================
module aes_edn_arbiter #(
    parameter int NumReq       = 2,
    parameter int EntropyWidth = 32,
    parameter int MaxWait      = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    aes_edn_arbiter_if.slave  bus
);
    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = 4;
    localparam logic [CntW-1:0] c_max_wait = CntW'(MaxWait);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    state_e                       r_state;
    state_e                       w_state_nxt;
    logic [IdxW-1:0]              r_gnt_idx;
    logic [IdxW-1:0]              w_gnt_nxt;
    logic [IdxW-1:0]              w_winner;
    logic                         w_found;
    logic                         r_edn_req;
    logic                         r_err;
    logic                         w_err_nxt;
    logic                         w_grant;
    logic [NumReq-1:0]            w_ack;
    logic [NumReq-1:0]            w_starved;
    logic [NumReq-1:0][CntW-1:0]  r_wait;

`ifdef AES_EDN_ARB_RR_EN
    localparam logic [IdxW:0] c_num_req_w = (IdxW+1)'(NumReq);
    logic [IdxW-1:0] r_rr_ptr;
    logic [IdxW:0]   w_sum;
`endif

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_starved[i] = bus.req_i[i] && (r_wait[i] == c_max_wait);
        end
    end

    // Starved requesters always win, lowest index first.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
`ifdef AES_EDN_ARB_RR_EN
        w_sum    = '0;
`endif
        for (int i = 0; i < NumReq; i++) begin
            if (!w_found && w_starved[i]) begin
                w_winner = IdxW'(i);
                w_found  = 1'b1;
            end
        end
`ifdef AES_EDN_ARB_RR_EN
        for (int k = 0; k < NumReq; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IdxW+1)'(k + 1);
            if (w_sum >= c_num_req_w) begin
                w_sum = w_sum - c_num_req_w;
            end
            if (!w_found && bus.req_i[w_sum[IdxW-1:0]]) begin
                w_winner = w_sum[IdxW-1:0];
                w_found  = 1'b1;
            end
        end
`else
        for (int i = 0; i < NumReq; i++) begin
            if (!w_found && bus.req_i[i]) begin
                w_winner = IdxW'(i);
                w_found  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_idx;
        w_err_nxt   = r_err;
        w_grant     = 1'b0;
        w_ack       = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.edn_ack_i) begin
                    w_err_nxt = 1'b1;
                end
                if (|bus.req_i) begin
                    w_state_nxt = ST_BUSY;
                    w_gnt_nxt   = w_winner;
                    w_grant     = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus.req_i[r_gnt_idx]) begin
                    if (bus.edn_ack_i) begin
                        w_ack[r_gnt_idx] = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end
                end else begin
                    // Abandoned: EDN still owes us a word, keep asking for it.
                    w_state_nxt = bus.edn_ack_i ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.edn_ack_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_DRAIN;
                w_err_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= '0;
            r_edn_req <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_nxt;
            r_edn_req <= (w_state_nxt != ST_IDLE);
            r_err     <= w_err_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (w_ack[i] || ((r_state == ST_IDLE) && !bus.req_i[i])) begin
                    r_wait[i] <= '0;
                end else if (w_grant && bus.req_i[i] && (w_winner != IdxW'(i)) &&
                             (r_wait[i] != c_max_wait)) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
        end
    end

`ifdef AES_EDN_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= IdxW'(NumReq - 1);
        end else if (|w_ack) begin
            r_rr_ptr <= r_gnt_idx;
        end
    end
`endif

    assign bus.ack_o     = w_ack;
    assign bus.data_o    = (|w_ack) ? bus.edn_data_i : '0;
    assign bus.edn_req_o = r_edn_req;
    assign bus.gnt_idx_o = r_gnt_idx;
    assign bus.idle_o    = (r_state == ST_IDLE) && !(|bus.req_i);
    assign bus.err_o     = r_err;

endmodule
`default_nettype wire
